// File: rtl/ahb_apb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ahb_apb_pkg
// Purpose  : Shared types, response codes and helpers for the AHB slave
//            front end of the AHB-to-APB bridge.
// Revision : 1.0 - initial release
// ============================================================================
package ahb_apb_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'd0,
    HT_BUSY   = 2'd1,
    HT_NONSEQ = 2'd2,
    HT_SEQ    = 2'd3
  } htrans_t;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    OKAY = 2'd0,
    ERR1 = 2'd1,
    ERR2 = 2'd2
  } fe_state_t;

  // An access of 2^size bytes is aligned when the low size address bits are 0.
  function automatic logic is_aligned(input logic [7:0] addr, input logic [2:0] size);
    logic [7:0] mask;
    mask = (8'd1 << size) - 8'd1;
    return (addr & mask) == 8'd0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_addr_decode.sv
`default_nettype none
// ============================================================================
// Module   : ahb_addr_decode
// Purpose  : Combinational APB window decoder. Splits the window starting at
//            BASE_ADDR into NUM_SLV regions of 2^REGION_LOG2 bytes and
//            produces a one-hot select plus a mapped flag.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_addr_decode #(
  parameter int                ADDR_W      = 32,
  parameter int                NUM_SLV     = 3,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int                REGION_LOG2 = 26
) (
  input  logic [ADDR_W-1:0]  haddr,
  output logic               mapped,
  output logic [NUM_SLV-1:0] tempselx
);

  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] idx;

  // Working on the offset avoids overflow when the window touches the top of
  // the address space.
  assign offset = haddr - BASE_ADDR;
  assign idx    = offset >> REGION_LOG2;
  assign mapped = (haddr >= BASE_ADDR) && (idx < ADDR_W'(NUM_SLV));

  generate
    for (genvar i = 0; i < NUM_SLV; i++) begin : g_sel
      assign tempselx[i] = mapped && (idx == ADDR_W'(i));
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/ahb_slave_frontend.sv
`default_nettype none
// ============================================================================
// Module   : ahb_slave_frontend
// Purpose  : AHB slave side of the AHB-to-APB bridge: address/data pipeline,
//            slave decode, transfer legality check, two-cycle ERROR response
//            and a saturating error counter.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_slave_frontend
  import ahb_apb_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                NUM_SLV     = 3,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int                REGION_LOG2 = 26
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hsel,
  input  logic [ADDR_W-1:0]  haddr,
  input  logic [1:0]         htrans,
  input  logic               hwrite,
  input  logic [2:0]         hsize,
  input  logic [DATA_W-1:0]  hwdata,
  input  logic               hreadyin,
  input  logic               bridge_ready,
  input  logic [DATA_W-1:0]  prdata,
  output logic               hreadyout,
  output logic [1:0]         hresp,
  output logic [DATA_W-1:0]  hrdata,
  output logic               valid,
  output logic [NUM_SLV-1:0] tempselx,
  output logic [ADDR_W-1:0]  haddr1,
  output logic [ADDR_W-1:0]  haddr2,
  output logic [DATA_W-1:0]  hwdata1,
  output logic [DATA_W-1:0]  hwdata2,
  output logic               hwritereg,
  output logic [15:0]        err_count
);

  // Largest legal hsize: log2 of the bus width in bytes.
  localparam logic [2:0] MAX_SIZE = (DATA_W == 64) ? 3'd3 : 3'd2;

  fe_state_t          state;
  logic [1:0]         hresp_q;
  logic               err_ready_q;
  logic [15:0]        err_count_q;
  logic [15:0]        err_count_d;
  logic               mapped;
  logic [NUM_SLV-1:0] dec_sel;
  logic               active;
  logic               bad;
  logic               illegal;

  ahb_addr_decode #(
    .ADDR_W      (ADDR_W),
    .NUM_SLV     (NUM_SLV),
    .BASE_ADDR   (BASE_ADDR),
    .REGION_LOG2 (REGION_LOG2)
  ) u_decode (
    .haddr    (haddr),
    .mapped   (mapped),
    .tempselx (dec_sel)
  );

  // NONSEQ and SEQ are exactly the htrans codes with bit 1 set.
  assign active  = hsel && hreadyin && htrans[1];
  assign bad     = !mapped || (hsize > MAX_SIZE) || !is_aligned(haddr[7:0], hsize);
  // Only OKAY evaluates transfers; a transfer seen in ERR2 is being cancelled.
  assign illegal = active && bad && (state == OKAY);

  assign valid     = rst_n && active && !bad && (state == OKAY);
  assign tempselx  = rst_n ? dec_sel : '0;
  assign hresp     = rst_n ? hresp_q : HRESP_OKAY;
  assign hreadyout = !rst_n ? 1'b1 : ((state == OKAY) ? bridge_ready : err_ready_q);
  assign hrdata    = prdata;
  assign err_count = err_count_q;

  // Address, write-data and direction pipeline, advancing only on hreadyin.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      haddr1    <= '0;
      haddr2    <= '0;
      hwdata1   <= '0;
      hwdata2   <= '0;
      hwritereg <= 1'b0;
    end else if (hreadyin) begin
      haddr1    <= haddr;
      haddr2    <= haddr1;
      hwdata1   <= hwdata;
      hwdata2   <= hwdata1;
      hwritereg <= hwrite;
    end
  end

  // Response FSM: OKAY -> ERR1 (wait state) -> ERR2 (ERROR completes) -> OKAY.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= OKAY;
      hresp_q     <= HRESP_OKAY;
      err_ready_q <= 1'b1;
    end else begin
      case (state)
        OKAY: begin
          if (illegal) begin
            state       <= ERR1;
            hresp_q     <= HRESP_ERROR;
            err_ready_q <= 1'b0;
          end
        end
        ERR1: begin
          state       <= ERR2;
          hresp_q     <= HRESP_ERROR;
          err_ready_q <= 1'b1;
        end
        ERR2: begin
          state       <= OKAY;
          hresp_q     <= HRESP_OKAY;
          err_ready_q <= 1'b1;
        end
        default: begin
          state       <= OKAY;
          hresp_q     <= HRESP_OKAY;
          err_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Next error count: one step per entry into ERR1, pinned at all-ones.
  always_comb begin
    err_count_d = err_count_q;
    if (illegal && (err_count_q != 16'hFFFF)) begin
      err_count_d = err_count_q + 16'd1;
    end
  end

  // Error counter register, loaded every cycle from its next-value logic.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_count_q <= '0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

endmodule
`default_nettype wire
